// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out word receiver.
// Assembles a framed serial bit stream into WIDTH-bit words, either LSB-first or
// MSB-first. Each finished word goes to a one-entry valid/ready output buffer.
// Two sticky flags report overrun and framing errors.
//
// state | meaning
// IDLE  | waiting for a sof-qualified bit to start a frame
// RECV  | frame in progress, collecting bits 1..WIDTH-1
module serial_word_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             dir_q, dir_nxt;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             early_sof;

  // dir=0 shifts right with the new bit entering at the MSB, so the first bit ends in bit 0;
  // dir=1 shifts left with the new bit entering at the LSB, so the first bit ends at the MSB.
  function automatic logic [WIDTH-1:0] shift_bit(input logic [WIDTH-1:0] cur,
                                                 input logic d, input logic b);
    return d ? {cur[WIDTH-2:0], b} : {b, cur[WIDTH-1:1]};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and bit-assembly logic. Each sof-qualified bit restarts the frame from an empty register.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    count_nxt = count;
    dir_nxt   = dir_q;
    word      = shift_bit(shreg, dir_q, sin);
    complete  = 1'b0;
    early_sof = 1'b0;
    if (sin_en) begin
      if (sof) begin
        early_sof = (state == RECV);
        state_nxt = RECV;
        dir_nxt   = dir;
        shreg_nxt = shift_bit('0, dir, sin);
        count_nxt = CW'(1);
      end else if (state == RECV) begin
        if (count == LAST) begin
          complete  = 1'b1;
          state_nxt = IDLE;
          shreg_nxt = '0;
          count_nxt = '0;
        end else begin
          shreg_nxt = word;
          count_nxt = count + CW'(1);
        end
      end
    end
  end

  // Output decode.
  always_comb begin
    busy = (state == RECV);
  end

  // Shift register, bit counter and latched bit order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
      dir_q <= 1'b0;
    end else begin
      shreg <= shreg_nxt;
      count <= count_nxt;
      dir_q <= dir_nxt;
    end
  end

  // Output buffer: a completed word loads when the buffer is empty or is consumed at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (complete && (!dout_valid || dout_ready)) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky error flags. A set event takes priority over clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (complete && dout_valid && !dout_ready) || (overrun && !clr_err);
      frame_err <= early_sof || (frame_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Testbench for serial_word_receiver.
// The bench runs the directed scenarios first and then a randomized phase.
// It compares the DUT against a queue-based reference model of the frame protocol.
module tb_serial_word_receiver;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, sin, sin_en, sof, dir, dout_ready, clr_err;
  logic [W-1:0] dout;
  logic         dout_valid, busy, overrun, frame_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           m_in_frame;
  bit           m_dir;
  bit           q_bits[$];
  logic [W-1:0] m_dout;
  bit           m_valid, m_ov, m_fe;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sof(sof), .dir(dir),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (!m_dir) w[i] = q_bits[i];
      else        w[W-1-i] = q_bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_dir = 0; q_bits.delete();
    m_dout = '0; m_valid = 0; m_ov = 0; m_fe = 0;
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit           complete = 0, ov_set = 0, fe_set = 0;
    logic [W-1:0] w = '0;
    if (sin_en) begin
      if (sof) begin
        if (m_in_frame) fe_set = 1;
        q_bits.delete();
        q_bits.push_back(sin);
        m_dir = dir;
        m_in_frame = 1;
      end else if (m_in_frame) begin
        q_bits.push_back(sin);
        if (q_bits.size() == W) begin
          w = assemble();
          complete = 1;
          m_in_frame = 0;
          q_bits.delete();
        end
      end
    end
    if (complete) begin
      if (!m_valid || dout_ready) begin
        m_dout = w;
        m_valid = 1;
      end else begin
        ov_set = 1;
      end
    end else if (m_valid && dout_ready) begin
      m_valid = 0;
    end
    m_ov = ov_set || (m_ov && !clr_err);
    m_fe = fe_set || (m_fe && !clr_err);
  endtask

  task automatic check_all();
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_valid);
    chk("busy", busy, m_in_frame);
    chk("overrun", overrun, m_ov);
    chk("frame_err", frame_err, m_fe);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    sin_en = 0; sof = 0; sin = 0; dout_ready = 0; clr_err = 0;
  endtask

  task automatic send_bit(input bit b, input bit s, input bit d, input bit rdy);
    sin_en = 1; sof = s; sin = b; dir = d; dout_ready = rdy; clr_err = 0;
    step();
    idle_inputs();
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit d, input int maxgap, input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      int gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        idle_inputs();
        step();
      end
      send_bit(d ? word[W-1-i] : word[i], i == 0, d, (i == W-1) ? rdy_last : 1'b0);
    end
  endtask

  task automatic consume();
    idle_inputs();
    dout_ready = 1;
    step();
    idle_inputs();
  endtask

  initial begin
    rst_n = 0; dir = 0;
    idle_inputs();
    model_reset();
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1;

    // 1: LSB-first 0x12
    send_frame(8'h12, 0, 0, 0);
    chk("t1_dout", dout, 8'h12);
    chk("t1_valid", dout_valid, 1);
    chk("t1_busy", busy, 0);
    consume();

    // 2: MSB-first, same bits with gaps -> 0x48, then consume
    send_frame(8'h48, 1, 3, 0);
    chk("t2_dout", dout, 8'h48);
    chk("t2_valid", dout_valid, 1);
    consume();
    chk("t2_consumed", dout_valid, 0);

    // 3: overrun and clear
    send_frame(8'h12, 0, 0, 0);
    send_frame(8'hFF, 0, 1, 0);
    chk("t3_dout_kept", dout, 8'h12);
    chk("t3_overrun", overrun, 1);
    chk("t3_idle", busy, 0);
    clr_err = 1;
    step();
    clr_err = 0;
    chk("t3_cleared", overrun, 0);

    // 4: consume and complete on the same edge
    send_frame(8'h34, 0, 2, 1);
    chk("t4_dout", dout, 8'h34);
    chk("t4_valid", dout_valid, 1);
    chk("t4_no_overrun", overrun, 0);
    consume();

    // 5: early sof after 3 bits
    send_bit(1, 1, 0, 0);
    send_bit(0, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_frame(8'hFF, 0, 0, 0);
    chk("t5_frame_err", frame_err, 1);
    chk("t5_dout", dout, 8'hFF);
    chk("t5_valid", dout_valid, 1);
    consume();
    clr_err = 1;
    step();
    clr_err = 0;
    chk("t5_cleared", frame_err, 0);

    // 6: reset mid-frame, then a clean 0xA5
    send_frame(8'h55, 0, 0, 0);
    send_bit(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) send_bit(1, 0, 1, 0);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_frame_err", frame_err, 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1;
    send_frame(8'hA5, 0, 1, 0);
    chk("t6_dout", dout, 8'hA5);
    chk("t6_valid", dout_valid, 1);
    chk("t6_frame_err", frame_err, 0);
    consume();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sin_en     = ($urandom_range(1, 0) == 1);
      sof        = ($urandom_range(9, 0) == 0);
      sin        = $urandom_range(1, 0);
      dir        = $urandom_range(1, 0);
      dout_ready = ($urandom_range(2, 0) == 0);
      clr_err    = ($urandom_range(19, 0) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-in, parallel-out receiver; the receiving end of the team's 8-bit serial/parallel shift register.
- Collects a framed serial bit stream (bit strobe + start-of-frame) into WIDTH-bit words, LSB-first or MSB-first.
- Hands each word to downstream logic through a one-entry valid/ready output buffer.
- Flags overrun and framing errors.

Parameters:
- WIDTH, 8, word length in bits (WIDTH >= 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sin  in  1  serial data bit; sampled only when sin_en=1.
- sin_en  in  1  bit strobe; one bit accepted per cycle with sin_en=1.
- sof  in  1  start of frame; qualified by sin_en; marks the current bit as bit 0 of a new word.
- dir  in  1  bit order, sampled with the sof bit and held for the frame. 0 = LSB first (shift right, enter at MSB). 1 = MSB first (shift left, enter at LSB).
- dout  out  WIDTH  received word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  downstream accepts dout when dout_valid=1.
- busy  out  1  frame in progress (state RECV).
- overrun  out  1  sticky; a completed word was dropped.
- frame_err  out  1  sticky; a frame was aborted by an early sof.
- clr_err  in  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (rst_n=0, async) forces:
  - dout=0, dout_valid=0, busy=0, overrun=0, frame_err=0
  - shift register=0, bit counter=0, state=IDLE.
- FSM, two states:
  - IDLE: sin_en=1 with sof=0 is ignored. sin_en=1 with sof=1 captures sin as bit 0, latches dir, sets count=1 and goes to RECV.
  - RECV: each sin_en=1 shifts sin in per the latched dir and increments count. Cycles with sin_en=0 hold all state; gaps of any length are allowed.
- Word completion: at the edge sampling bit WIDTH-1 (count=WIDTH-1 and sin_en=1, sof=0):
  - The assembled word is written to dout; dout_valid=1 from the next cycle. Latency is 0 cycles after the last-bit edge.
  - State returns to IDLE and count returns to 0.
- Back-to-back frames are allowed: a sof bit in the cycle right after completion starts a new frame.
- LSB-first: the first received bit lands in dout[0]. MSB-first: the first received bit lands in dout[WIDTH-1].
- Output handshake:
  - dout_valid=1 and dout_ready=1 at an edge consumes the word; dout_valid falls unless a new word completes at the same edge.
  - Completion at the same edge as a consume loads the new word and keeps dout_valid=1; no overrun.
  - Completion while dout_valid=1 and dout_ready=0 drops the new word, keeps the old dout, and sets overrun. The FSM still returns to IDLE.
  - dout is stable while dout_valid=1 and unconsumed.
- Early sof in RECV (sin_en=1, sof=1, count != 0) discards the partial word, sets frame_err, and restarts with this bit as bit 0 with a newly latched dir. State stays RECV.
- Flags:
  - clr_err=1 clears both flags at the next edge.
  - If a set event coincides with clr_err, the set wins.
- Reset mid-frame discards the partial word and any buffered word.
- busy = (state == RECV).

Test Plan:
1. LSB-first, WIDTH=8, dir=0: strobe bits 0,1,0,0,1,0,0,0, sof on the first, dout_ready=0 -> dout=0x12, dout_valid=1 the cycle after the 8th strobe edge, busy=0.
2. MSB-first, dir=1: same bit sequence with gaps of 0-3 idle cycles between strobes -> dout=0x48. Then dout_ready=1 for one cycle -> dout_valid=0.
3. Overrun: receive 0x12 (LSB-first), hold dout_ready=0, receive a second frame encoding 0xFF -> dout stays 0x12, overrun=1. Then clr_err=1 -> overrun=0 next cycle.
4. Simultaneous consume and complete: dout_valid=1 (0x12), dout_ready=1 on the 8th-bit edge of a 0x34 frame -> dout=0x34, dout_valid stays 1, overrun=0.
5. Early sof: 3 bits, then sof with bits 1,1,1,1,1,1,1,1 (dir=0) -> frame_err=1, dout=0xFF valid after the 8th bit of the new frame.
6. Reset mid-frame: deassert rst_n asynchronously after 5 bits, then release and send a full 0xA5 frame -> all outputs 0 during reset, then dout=0xA5 with no residue from the partial frame.
